// File: rtl/rom_fetch_if.sv
// rom_fetch_if: control, ROM-side and output-stream signals of the instruction fetcher.
`timescale 1ns/1ps
interface rom_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  fetch_en;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  rom_error;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  out_error;
    logic                  halted;
    modport master (
        input  fetch_en, redirect_valid, redirect_addr, rom_data, rom_error, out_ready,
        output rom_addr, out_valid, out_instr, out_pc, out_error, halted
    );
    modport slave (
        output fetch_en, redirect_valid, redirect_addr, rom_data, rom_error, out_ready,
        input  rom_addr, out_valid, out_instr, out_pc, out_error, halted
    );
endinterface

// File: rtl/rom_fetch.sv
// rom_fetch: ROM instruction fetcher with a 2-entry output FIFO and redirect flush.
// Define ROM_FETCH_ERR_HALT_EN to halt fetching after capturing a word flagged by rom_error.
`timescale 1ns/1ps
module rom_fetch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic         clk,
    input logic         rst_n,
    rom_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_head;
    logic                  r_tail;
    logic [DATA_WIDTH-1:0] r_instr [2];
    logic [ADDR_WIDTH-1:0] r_tag [2];
    logic                  r_err [2];
    logic                  w_pop;
    logic                  w_cap;
    logic                  w_issue;
    logic [2:0]            w_occ;
`ifdef ROM_FETCH_ERR_HALT_EN
    logic                  r_halted;
    assign w_cap = r_inflight && r_state != HALT;
    assign bus.halted = r_halted;
`else
    assign w_cap = r_inflight;
    assign bus.halted = 1'b0;
`endif
    assign w_pop   = r_count != 2'd0 && bus.out_ready;
    // Space check counts the word already in flight so the FIFO can never overflow
    assign w_occ   = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = r_state == FETCH && bus.fetch_en && w_occ < 3'd2;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_rom_addr <= '0;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
            r_tag[0]   <= '0;
            r_tag[1]   <= '0;
            r_err[0]   <= 1'b0;
            r_err[1]   <= 1'b0;
`ifdef ROM_FETCH_ERR_HALT_EN
            r_halted   <= 1'b0;
`endif
        end else if (bus.redirect_valid) begin
            r_state    <= bus.fetch_en ? FETCH : IDLE;
            r_pc       <= bus.redirect_addr;
            r_rom_addr <= bus.redirect_addr;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
`ifdef ROM_FETCH_ERR_HALT_EN
            r_halted   <= 1'b0;
`endif
        end else begin
            if (w_issue) begin
                r_rom_addr <= r_pc;
                r_pc       <= r_pc + ADDR_WIDTH'(1);
            end
            r_inflight <= w_issue;
            // rom_addr still holds the issued address while its data is returned
            if (w_cap) begin
                r_instr[r_tail] <= bus.rom_data;
                r_tag[r_tail]   <= r_rom_addr;
                r_err[r_tail]   <= bus.rom_error;
                r_tail          <= ~r_tail;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + 2'(w_cap) - 2'(w_pop);
`ifdef ROM_FETCH_ERR_HALT_EN
            if (w_cap && bus.rom_error) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
            end else
`endif
            if (r_state == IDLE && bus.fetch_en)
                r_state <= FETCH;
            else if (r_state == FETCH && !bus.fetch_en)
                r_state <= IDLE;
        end
    end
    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_valid = r_count != 2'd0;
    assign bus.out_instr = r_instr[r_head];
    assign bus.out_pc    = r_tag[r_head];
    assign bus.out_error = r_err[r_head];
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed and random stimulus against an in-order word scoreboard.
`timescale 1ns/1ps
module tb_rom_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rom_fetch_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus();
    rom_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );
    logic       err_on = 1'b0;
    logic [7:0] err_addr = 8'h05;
    assign bus.rom_data  = {8'h00, bus.rom_addr} ^ 16'hA5A5;
    assign bus.rom_error = err_on && bus.rom_addr == err_addr;
    int n_chk = 0;
    int n_pass = 0;
    int n_words = 0;
    int n_err_words = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Scoreboard: each accepted word must be the next sequential address since reset/redirect
    logic [7:0]  exp_pc = 8'h00;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_instr;
    logic [7:0]  prev_pc;
    logic        prev_err;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 8'h00;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_pc", 32'(bus.out_pc), 32'(prev_pc));
                chk("hold_instr", 32'(bus.out_instr), 32'(prev_instr));
                chk("hold_err", 32'(bus.out_error), 32'(prev_err));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_pc", 32'(bus.out_pc), 32'(exp_pc));
                chk("sb_instr", 32'(bus.out_instr), 32'({8'h00, exp_pc} ^ 16'hA5A5));
                chk("sb_err", 32'(bus.out_error), 32'(err_on && exp_pc == err_addr));
                if (bus.out_error) n_err_words++;
                exp_pc = exp_pc + 8'd1;
                n_words++;
            end
            if (bus.redirect_valid) exp_pc = bus.redirect_addr;
            stall_prev = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            prev_instr = bus.out_instr;
            prev_pc    = bus.out_pc;
            prev_err   = bus.out_error;
        end
    end
    logic [7:0] wrap_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] saved_addr;
    int         w0;
    initial begin
        bus.fetch_en = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_instr", 32'(bus.out_instr), 32'd0);
        chk("rst_err", 32'(bus.out_error), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        rst_n = 1'b1;
        bus.fetch_en = 1'b1;
        tick();
        chk("lat_v1", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_v2", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_v3", 32'(bus.out_valid), 32'd1);
        chk("lat_pc", 32'(bus.out_pc), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_pc", 32'(bus.out_pc), 32'(i));
        end
        bus.out_ready = 1'b0;
        tick();
        saved_addr = bus.rom_addr;
        repeat (4) tick();
        chk("stall_rom_addr", 32'(bus.rom_addr), 32'(saved_addr));
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        repeat (10) tick();
        bus.out_ready = 1'b0;
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h40;
        tick();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("rd_v1", 32'(bus.out_valid), 32'd0);
        chk("rd_rom_addr", 32'(bus.rom_addr), 32'h40);
        tick();
        chk("rd_v2", 32'(bus.out_valid), 32'd0);
        tick();
        chk("rd_v3", 32'(bus.out_valid), 32'd1);
        chk("rd_pc", 32'(bus.out_pc), 32'h40);
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'hFE;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_valid", 32'(bus.out_valid), 32'd1);
            chk("wrap_pc", 32'(bus.out_pc), 32'(wrap_exp[i]));
        end
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_pc", 32'(bus.out_pc), 32'd0);
        chk("mrst_instr", 32'(bus.out_instr), 32'd0);
        chk("mrst_err", 32'(bus.out_error), 32'd0);
        chk("mrst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("mrst_halted", 32'(bus.halted), 32'd0);
        repeat (3) tick();
        chk("mrst_restart_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst_restart_pc", 32'(bus.out_pc), 32'd0);
        repeat (2) tick();
        err_on = 1'b1;
        n_err_words = 0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h00;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (11) tick();
`ifdef ROM_FETCH_ERR_HALT_EN
        chk("err_halted", 32'(bus.halted), 32'd1);
        chk("err_stopped", 32'(bus.out_valid), 32'd0);
`else
        chk("err_halted", 32'(bus.halted), 32'd0);
        chk("err_continues", 32'(bus.out_valid), 32'd1);
`endif
        chk("err_seen", 32'(n_err_words), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h10;
        tick();
        bus.redirect_valid = 1'b0;
        chk("resume_halted", 32'(bus.halted), 32'd0);
        err_on = 1'b0;
        tick();
        tick();
        chk("resume_valid", 32'(bus.out_valid), 32'd1);
        chk("resume_pc", 32'(bus.out_pc), 32'h10);
        w0 = n_words;
        for (int i = 0; i < 400; i++) begin
            bus.fetch_en = ($urandom % 8) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            bus.redirect_valid = ($urandom % 40) == 0;
            bus.redirect_addr = 8'($urandom_range(0, 255));
            tick();
            chk("rand_halted", 32'(bus.halted), 32'd0);
        end
        chk("rand_flow", 32'(n_words > w0 + 100), 32'd1);
        bus.redirect_valid = 1'b0;
        bus.fetch_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
